fpu_exp_pipe: RTL and testbench
===============================

Name: fpu_exp_pipe

Overview:
- Parametrised, pipelined successor to the FPU exponent unit.
- Computes the result exponent, alignment shift amount and operand swap for add, mul, div, pass and normalise operations.
- Supports any IEEE exponent width: single, double or extended.
- Sits between the microcode/ROM sequencer and the mantissa datapath. Uses a valid/ready handshake and the global fpuhold stall.

Parameters:
- EXP_W, 11, exponent field width (8 single, 11 double, 15 extended).
- BIAS, 1023, exponent bias; must equal 2^(EXP_W-1)-1.
- SA_W, 6, shift-amount width; sa saturates at 2^SA_W-1.
- LZC_W, 6, leading-zero-count width from the priority encoder.

Ports:
- clk  in  1  clock, rising edge.
- reset_l  in  1  asynchronous active-low reset.
- fpuhold  in  1  global stall; freezes all state.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept the request this cycle.
- op  in  3  0=ADD, 1=MUL, 2=DIV, 3=PASS, 4=NORM; 5-7 reserved, treated as PASS.
- aexp  in  EXP_W  operand A biased exponent.
- bexp  in  EXP_W  operand B biased exponent.
- lzc  in  LZC_W  normalise left-shift count (used by NORM).
- inc_ovf  in  1  mantissa rounding carry-out; adds 1 to the result.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- res_exp  out  EXP_W  result exponent, clamped.
- sa  out  SA_W  alignment right-shift amount.
- sa_sat  out  1  |a-b| exceeded 2^SA_W-1.
- swap  out  1  bexp>aexp (ADD only); mantissas must be swapped.
- expsame  out  1  aexp==bexp.
- ovf  out  1  result exponent overflow.
- unf  out  1  result exponent underflow.

Behaviour:
- Reset: all pipeline registers and all outputs are 0. in_ready=1 once reset_l deasserts. Reset mid-operation discards in-flight work; there is no partial output.
- Pipeline: two register stages, S1 (arithmetic) and S2 (adjust + flags). Latency is 2 cycles from accept to out_valid when there is no stall.
- Accept: a request is accepted when in_valid & in_ready & !fpuhold. in_ready = !fpuhold & (!s1_v | s2_adv), where s2_adv = !s2_v | out_ready.
- Output handshake: the output transfers when out_valid & out_ready & !fpuhold. Outputs stay stable while out_valid=1 and the transfer has not happened.
- fpuhold=1: no register changes, in_ready=0, outputs hold their values.
- Full pipe, out_ready=0: both stages hold and in_ready=0. Order is preserved; no drop, no duplicate.
- S1 arithmetic is signed, at EXP_W+2 bits.
  - ADD: d=a-b; t=max(a,b); swap=(d<0); sa=min(|d|, 2^SA_W-1); sa_sat=(|d|>2^SA_W-1).
  - MUL: t=a+b-BIAS.
  - DIV: t=a-b+BIAS.
  - PASS: t=a.
  - NORM: t=a-lzc.
  - expsame=(a==b) for every op.
  - sa, sa_sat and swap are 0 for every op other than ADD.
- S2 adjust: u=t+inc_ovf.
  - If u >= 2^EXP_W-1: ovf=1, res_exp=all-ones.
  - Else if u <= 0: unf=1, res_exp=0.
  - Else res_exp=u[EXP_W-1:0].
  - ovf and unf are mutually exclusive.
- lzc and inc_ovf are sampled with the request at accept; they are not sampled later.

Decomposition:
- Shared package fpu_exp_pkg holds:
  - op encodings (EXP_OP_ADD ... EXP_OP_NORM);
  - the bias function bias_of(EXP_W);
  - the signed intermediate width constant EXP_W+2.
- One natural sub-module: fpu_exp_clamp. It is combinational S2 logic: signed u in; res_exp, ovf and unf out.
- Handshake and stage registers stay in the top level.

Test Plan:
All cases use EXP_W=11, BIAS=1023, SA_W=6.
- ADD a=1030, b=1000 -> after 2 cycles: res_exp=1030, sa=30, swap=0, sa_sat=0, expsame=0.
- ADD a=1000, b=1100 -> res_exp=1100, sa=63, sa_sat=1, swap=1. ADD a=b=500 -> expsame=1, sa=0, res_exp=500.
- MUL 1100x1100 -> res_exp=1177. MUL 2000x2000 -> ovf=1, res_exp=2047. DIV a=10, b=1100 -> unf=1, res_exp=0.
- NORM a=1030, lzc=5, inc_ovf=1 -> res_exp=1026. NORM a=3, lzc=3 -> unf=1, res_exp=0.
- Issue 4 back-to-back requests with out_ready=0 -> in_ready drops after 2 accepts. Raise out_ready -> results emerge in issue order; the remaining 2 are then accepted.
- Assert fpuhold for 3 cycles mid-stream -> no output change and no accept. Assert reset_l=0 with 2 ops in flight -> out_valid=0 and all outputs 0 immediately (asynchronous); no stale result after release.

Source files
------------

// File: rtl/fpu_exp_pkg.sv
// Shared definitions for the pipelined FPU exponent unit: op encodings,
// bias helper and the width of the signed intermediate exponent.
package fpu_exp_pkg;

  typedef enum logic [2:0] {
    EXP_OP_ADD  = 3'd0,
    EXP_OP_MUL  = 3'd1,
    EXP_OP_DIV  = 3'd2,
    EXP_OP_PASS = 3'd3,
    EXP_OP_NORM = 3'd4
  } exp_op_e;

  // Two guard bits cover a+b-bias overflow and a-b+bias underflow.
  localparam int EXP_GUARD_BITS = 2;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int iw_of(input int exp_w);
    return exp_w + EXP_GUARD_BITS;
  endfunction

endpackage

// File: rtl/fpu_exp_clamp.sv
// Second-stage exponent adjust: clamps the signed intermediate exponent
// into the biased field and flags overflow / underflow.
module fpu_exp_clamp
  import fpu_exp_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int IW    = iw_of(EXP_W)
) (
  input  logic signed [IW-1:0]    u,
  output logic        [EXP_W-1:0] res_exp,
  output logic                    ovf,
  output logic                    unf
);

  localparam logic signed [IW-1:0] E_MAX = IW'((1 << EXP_W) - 1);

  always_comb begin
    ovf     = 1'b0;
    unf     = 1'b0;
    res_exp = u[EXP_W-1:0];
    if (u >= E_MAX) begin
      ovf     = 1'b1;
      res_exp = '1;
    end else if (u[IW-1] || (u == '0)) begin
      unf     = 1'b1;
      res_exp = '0;
    end
  end

endmodule

// File: rtl/fpu_exp_pipe.sv
// Two-stage exponent pipeline: S1 computes the raw exponent and alignment,
// S2 applies the rounding carry and clamps. Valid/ready with global fpuhold.
module fpu_exp_pipe
  import fpu_exp_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int BIAS  = bias_of(EXP_W),
  parameter int SA_W  = 6,
  parameter int LZC_W = 6
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             fpuhold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [EXP_W-1:0] aexp,
  input  logic [EXP_W-1:0] bexp,
  input  logic [LZC_W-1:0] lzc,
  input  logic             inc_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] res_exp,
  output logic [SA_W-1:0]  sa,
  output logic             sa_sat,
  output logic             swap,
  output logic             expsame,
  output logic             ovf,
  output logic             unf
);

  localparam int IW = iw_of(EXP_W);
  localparam logic signed [IW-1:0] BIAS_S = IW'(BIAS);
  localparam logic signed [IW-1:0] SA_MAX = IW'((1 << SA_W) - 1);

  exp_op_e              op_e;
  logic signed [IW-1:0] a_s, b_s, lzc_s, d, abs_d, t_nx;
  logic [SA_W-1:0]      sa_nx;
  logic                 sa_sat_nx, swap_nx;

  logic                 s1_v, s1_inc, s1_sa_sat, s1_swap, s1_same;
  logic signed [IW-1:0] s1_t, u;
  logic [SA_W-1:0]      s1_sa;

  logic [EXP_W-1:0]     c_res;
  logic                 c_ovf, c_unf, s2_adv;

  assign op_e  = exp_op_e'(op);
  assign a_s   = $signed(IW'(aexp));
  assign b_s   = $signed(IW'(bexp));
  assign lzc_s = $signed(IW'(lzc));

  always_comb begin
    d         = a_s - b_s;
    abs_d     = d[IW-1] ? -d : d;
    t_nx      = a_s;
    sa_nx     = '0;
    sa_sat_nx = 1'b0;
    swap_nx   = 1'b0;
    case (op_e)
      EXP_OP_ADD: begin
        t_nx      = d[IW-1] ? b_s : a_s;
        swap_nx   = d[IW-1];
        sa_sat_nx = (abs_d > SA_MAX);
        sa_nx     = sa_sat_nx ? '1 : abs_d[SA_W-1:0];
      end
      EXP_OP_MUL:  t_nx = a_s + b_s - BIAS_S;
      EXP_OP_DIV:  t_nx = a_s - b_s + BIAS_S;
      EXP_OP_NORM: t_nx = a_s - lzc_s;
      default:     t_nx = a_s;  // PASS and reserved encodings
    endcase
  end

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !fpuhold && (!s1_v || s2_adv);
  assign u        = s1_t + $signed(IW'(s1_inc));

  fpu_exp_clamp #(.EXP_W(EXP_W), .IW(IW)) u_clamp (
    .u       (u),
    .res_exp (c_res),
    .ovf     (c_ovf),
    .unf     (c_unf)
  );

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      s1_v      <= 1'b0;
      s1_t      <= '0;
      s1_inc    <= 1'b0;
      s1_sa     <= '0;
      s1_sa_sat <= 1'b0;
      s1_swap   <= 1'b0;
      s1_same   <= 1'b0;
      out_valid <= 1'b0;
      res_exp   <= '0;
      sa        <= '0;
      sa_sat    <= 1'b0;
      swap      <= 1'b0;
      expsame   <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_t      <= t_nx;
          s1_inc    <= inc_ovf;
          s1_sa     <= sa_nx;
          s1_sa_sat <= sa_sat_nx;
          s1_swap   <= swap_nx;
          s1_same   <= (aexp == bexp);
        end
      end
      // Output registers only reload when a new result arrives so an idle
      // pipe keeps its last values instead of toggling.
      if (!fpuhold && s2_adv) begin
        out_valid <= s1_v;
        if (s1_v) begin
          res_exp <= c_res;
          sa      <= s1_sa;
          sa_sat  <= s1_sa_sat;
          swap    <= s1_swap;
          expsame <= s1_same;
          ovf     <= c_ovf;
          unf     <= c_unf;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_exp_pipe.sv
// Self-checking bench for fpu_exp_pipe: directed vectors with literal
// expectations plus a queue-based reference model checked on every transfer.
module tb_fpu_exp_pipe;

  localparam int EXP_W = 11;
  localparam int SA_W  = 6;
  localparam int LZC_W = 6;

  logic             clk = 1'b0;
  logic             reset_l = 1'b0;
  logic             fpuhold = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [2:0]       op = '0;
  logic [EXP_W-1:0] aexp = '0, bexp = '0;
  logic [LZC_W-1:0] lzc = '0;
  logic             inc_ovf = 1'b0;
  logic             in_ready, out_valid, sa_sat, swap, expsame, ovf, unf;
  logic [EXP_W-1:0] res_exp;
  logic [SA_W-1:0]  sa;

  int checks = 0, errors = 0, accepted = 0, delivered = 0;

  typedef struct {int res; int sa; int sat; int swap; int same; int ovf; int unf;} res_t;
  res_t expq[$];
  res_t snap;
  bit   hold_pend = 0;

  always #5 clk = ~clk;

  fpu_exp_pipe #(.EXP_W(EXP_W), .BIAS(1023), .SA_W(SA_W), .LZC_W(LZC_W)) dut (
    .clk(clk), .reset_l(reset_l), .fpuhold(fpuhold),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .aexp(aexp), .bexp(bexp), .lzc(lzc), .inc_ovf(inc_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_exp(res_exp), .sa(sa), .sa_sat(sa_sat), .swap(swap),
    .expsame(expsame), .ovf(ovf), .unf(unf)
  );

  function automatic res_t model(int o, int a, int b, int l, int i);
    res_t r = '{0, 0, 0, 0, 0, 0, 0};
    int t, u, ad;
    r.same = (a == b);
    case (o)
      0: begin
        t      = (a >= b) ? a : b;
        r.swap = (b > a);
        ad     = (a > b) ? a - b : b - a;
        r.sat  = (ad > 63);
        r.sa   = (ad > 63) ? 63 : ad;
      end
      1:       t = a + b - 1023;
      2:       t = a - b + 1023;
      4:       t = a - l;
      default: t = a;
    endcase
    u = t + i;
    if (u >= 2047)   begin r.ovf = 1; r.res = 2047; end
    else if (u <= 0) begin r.unf = 1; r.res = 0; end
    else r.res = u;
    return r;
  endfunction

  function automatic res_t dut_now();
    res_t r;
    r.res = res_exp; r.sa = sa; r.sat = sa_sat; r.swap = swap;
    r.same = expsame; r.ovf = ovf; r.unf = unf;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp(string nm, res_t a, res_t e);
    chk({nm, " res_exp"}, a.res,  e.res);
    chk({nm, " sa"},      a.sa,   e.sa);
    chk({nm, " sa_sat"},  a.sat,  e.sat);
    chk({nm, " swap"},    a.swap, e.swap);
    chk({nm, " expsame"}, a.same, e.same);
    chk({nm, " ovf"},     a.ovf,  e.ovf);
    chk({nm, " unf"},     a.unf,  e.unf);
  endtask

  // Compare process: results against the model queue, plus output stability.
  always @(negedge clk) begin
    if (!reset_l) hold_pend = 0;
    else begin
      if (hold_pend) begin
        chk("stable out_valid", out_valid, 1);
        cmp("stable", dut_now(), snap);
      end
      if (out_valid && out_ready && !fpuhold) begin
        delivered++;
        if (expq.size() == 0) chk("spurious output", 1, 0);
        else cmp("result", dut_now(), expq.pop_front());
      end
      hold_pend = out_valid && !(out_ready && !fpuhold);
      snap = dut_now();
      if (in_valid && in_ready && !fpuhold) begin
        accepted++;
        expq.push_back(model(op, aexp, bexp, lzc, inc_ovf));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(int o, int a, int b, int l, int i);
    bit done = 0;
    op = o[2:0]; aexp = a[EXP_W-1:0]; bexp = b[EXP_W-1:0];
    lzc = l[LZC_W-1:0]; inc_ovf = i[0]; in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      done = in_ready && !fpuhold;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("accept timeout", 0, 1);
  endtask

  task automatic check_op(string nm, int o, int a, int b, int l, int i,
                          int e_res, int e_sa, int e_sat, int e_swap,
                          int e_same, int e_ovf, int e_unf);
    res_t e;
    int n;
    e = '{e_res, e_sa, e_sat, e_swap, e_same, e_ovf, e_unf};
    cmp({nm, " model"}, model(o, a, b, l, i), e);
    out_ready = 1'b1;
    send(o, a, b, l, i);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    chk({nm, " latency"}, n, 2);
    chk({nm, " dut res_exp"}, res_exp, e_res);
    @(posedge clk); #1;
  endtask

  task automatic drain(string nm);
    int n = 0;
    out_ready = 1'b1;
    while (expq.size() != 0 && n < 30) begin @(negedge clk); n++; end
    chk({nm, " drained"}, expq.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc0;
    #12;
    cmp("reset", dut_now(), '{0, 0, 0, 0, 0, 0, 0});
    chk("reset out_valid", out_valid, 0);
    @(posedge clk); #1;
    reset_l = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", in_ready, 1);
    @(posedge clk); #1;

    //        name          op  a     b     lzc inc  res  sa sat sw same ovf unf
    check_op("add 1030-1000", 0, 1030, 1000, 0, 0, 1030, 30, 0, 0, 0, 0, 0);
    check_op("add 1000-1100", 0, 1000, 1100, 0, 0, 1100, 63, 1, 1, 0, 0, 0);
    check_op("add 500=500",   0, 500,  500,  0, 0, 500,  0,  0, 0, 1, 0, 0);
    check_op("add d=63",      0, 100,  37,   0, 0, 100,  63, 0, 0, 0, 0, 0);
    check_op("add d=64",      0, 100,  36,   0, 0, 100,  63, 1, 0, 0, 0, 0);
    check_op("mul 1100x1100", 1, 1100, 1100, 0, 0, 1177, 0,  0, 0, 1, 0, 0);
    check_op("mul 2000x2000", 1, 2000, 2000, 0, 0, 2047, 0,  0, 0, 1, 1, 0);
    check_op("mul u=2046",    1, 1534, 1534, 0, 1, 2046, 0,  0, 0, 1, 0, 0);
    check_op("mul u=2047",    1, 1535, 1534, 0, 1, 2047, 0,  0, 0, 0, 1, 0);
    check_op("div 10/1100",   2, 10,   1100, 0, 0, 0,    0,  0, 0, 0, 0, 1);
    check_op("norm 1030-5+1", 4, 1030, 0,    5, 1, 1026, 0,  0, 0, 0, 0, 0);
    check_op("norm 3-3",      4, 3,    0,    3, 0, 0,    0,  0, 0, 0, 0, 1);
    check_op("norm 3-2",      4, 3,    0,    2, 0, 1,    0,  0, 0, 0, 0, 0);
    check_op("reserved op",   5, 77,   77,   9, 0, 77,   0,  0, 0, 1, 0, 0);

    // Backpressure: two accepts fill the pipe, then in_ready must stay low.
    out_ready = 1'b0;
    acc0 = accepted;
    send(0, 1030, 1000, 0, 0);
    send(1, 1100, 1100, 0, 0);
    op = 3'd2; aexp = 11'd1100; bexp = 11'd10; lzc = '0; inc_ovf = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full in_ready", in_ready, 0);
      chk("full out_valid", out_valid, 1);
    end
    chk("full accept count", accepted - acc0, 2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2, 1100, 10, 0, 0);
    send(4, 900, 0, 7, 1);
    drain("backpressure");
    chk("backpressure delivered", delivered, accepted);

    // fpuhold for 3 cycles while a result is waiting and a request is pending.
    out_ready = 1'b1;
    send(3, 321, 5, 0, 0);
    @(posedge clk); #1;
    fpuhold = 1'b1;
    op = 3'd4; aexp = 11'd1030; bexp = '0; lzc = 6'd5; inc_ovf = 1'b1; in_valid = 1'b1;
    acc0 = accepted;
    repeat (3) begin
      @(negedge clk);
      chk("hold in_ready", in_ready, 0);
      chk("hold out_valid", out_valid, 1);
      chk("hold res_exp", res_exp, 321);
    end
    chk("hold no accept", accepted - acc0, 0);
    @(posedge clk); #1;
    fpuhold = 1'b0;
    send(4, 1030, 0, 5, 1);
    drain("fpuhold");

    // Asynchronous reset with two ops in flight.
    out_ready = 1'b0;
    send(0, 1030, 1000, 0, 0);
    send(1, 2000, 2000, 0, 0);
    reset_l = 1'b0;
    expq.delete();
    #1;
    chk("async reset out_valid", out_valid, 0);
    cmp("async reset", dut_now(), '{0, 0, 0, 0, 0, 0, 0});
    @(posedge clk); #1;
    reset_l = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no stale result", out_valid, 0);
    end
    @(posedge clk); #1;
    check_op("post-reset add", 0, 600, 610, 0, 0, 610, 10, 0, 1, 0, 0, 0);
    chk("final queue empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
